gray_codec_pipe: RTL and testbench

- Parametrised, pipelined successor to the 4-bit combinational Gray-to-binary decoder.
- Converts WIDTH-bit words Gray->binary or binary->Gray, selected per transaction.
- Two registered stages with valid/ready handshakes on both sides, plus a transfer counter.
- Sits between encoder/sensor front-ends and downstream arithmetic logic.

---
 rtl/gray_pkg.sv | 32 +++
 rtl/gray_prefix_xor.sv | 15 +
 rtl/gray_codec_pipe.sv | 115 +++++++++++
 tb/tb_gray_codec_pipe.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray codec pipeline.
// Holds the per-word mode encoding and generic Gray helpers. The helpers work
// on MAX_W-bit words; callers zero-extend their input and truncate the result
// to their own width.
package gray_pkg;

  localparam logic MODE_G2B = 1'b0;
  localparam logic MODE_B2G = 1'b1;
  localparam int   MAX_W    = 32;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Running XOR taken from bit n-1 downwards: r[i] = ^v[n-1:i] for i < n.
  // Bits at or above n read as zero.
  function automatic logic [MAX_W-1:0] prefix_xor(input logic [MAX_W-1:0] v,
                                                   input int n);
    logic [MAX_W-1:0] r;
    logic             acc;
    r   = '0;
    acc = 1'b0;
    for (int i = MAX_W - 1; i >= 0; i--) begin
      if (i < n) begin
        acc  = acc ^ v[i];
        r[i] = acc;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/gray_prefix_xor.sv
// Suffix-XOR network: o_vec[i] = XOR of i_vec[N-1:i].
// Ports:
//   i_vec  in  N  input vector
//   o_vec  out N  suffix-XOR result
module gray_prefix_xor #(
  parameter int N = 2
) (
  input  logic [N-1:0] i_vec,
  output logic [N-1:0] o_vec
);
  import gray_pkg::*;

  assign o_vec = N'(prefix_xor(MAX_W'(i_vec), N));

endmodule

// File: rtl/gray_codec_pipe.sv
// Two-stage pipelined Gray<->binary converter with valid/ready on both sides
// and a completed-transfer counter.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      input handshake (in_ready combinational from out_ready)
//   in_mode, in_data       0 = Gray->binary, 1 = binary->Gray; word to convert
//   out_valid/out_ready    output handshake
//   out_mode, out_data     mode carried with the word; converted word
//   xfer_count             completed output transfers, wrapping
module gray_codec_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] xfer_count
);
  import gray_pkg::*;

  localparam int H = WIDTH / 2;   // lower half width
  localparam int U = WIDTH - H;   // upper half width (wider for odd WIDTH)

  logic             r_s1_valid;
  logic             r_s1_mode;
  logic [WIDTH-1:0] r_s1_data;
  logic             r_s2_valid;
  logic             r_s2_mode;
  logic [WIDTH-1:0] r_s2_data;
  logic [CNT_W-1:0] r_cnt;

  logic             w_en1;
  logic             w_en2;
  logic [U-1:0]     w_upper_bin;
  logic [H-1:0]     w_lower_sx;
  logic             w_p;
  logic [WIDTH-1:0] w_s1_next;
  logic [WIDTH-1:0] w_s2_next;

  assign w_en2    = !r_s2_valid || out_ready;
  assign w_en1    = !r_s1_valid || w_en2;
  assign in_ready = w_en1;

  gray_prefix_xor #(.N(U)) u_upper (
    .i_vec (in_data[WIDTH-1:H]),
    .o_vec (w_upper_bin)
  );

  gray_prefix_xor #(.N(H)) u_lower (
    .i_vec (r_s1_data[H-1:0]),
    .o_vec (w_lower_sx)
  );

  // In G2B, stage 1 holds {binary upper half, raw Gray lower half}; the
  // carry P = b[H] is therefore simply the lowest bit of the registered
  // upper half.
  assign w_p = r_s1_data[H];

  always_comb begin
    w_s1_next = WIDTH'(bin2gray(MAX_W'(in_data)));
    if (in_mode == MODE_G2B) begin
      w_s1_next = {w_upper_bin, in_data[H-1:0]};
    end
  end

  always_comb begin
    w_s2_next = r_s1_data;
    if (r_s1_mode == MODE_G2B) begin
      w_s2_next = {r_s1_data[WIDTH-1:H], {H{w_p}} ^ w_lower_sx};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 1'b0;
      r_s1_data  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_mode  <= 1'b0;
      r_s2_data  <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_en2) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_mode <= r_s1_mode;
          r_s2_data <= w_s2_next;
        end
      end
      if (w_en1) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_mode <= in_mode;
          r_s1_data <= w_s1_next;
        end
      end
      if (r_s2_valid && out_ready) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_mode   = r_s2_mode;
  assign out_data   = r_s2_data;
  assign xfer_count = r_cnt;

endmodule

// File: tb/tb_gray_codec_pipe.sv
module tb_gray_codec_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_mode;
  logic [7:0] din;
  logic       out_ready;

  logic        ready4, ready5, ready8;
  logic        valid4, valid5, valid8;
  logic        mode4, mode5, mode8;
  logic [3:0]  data4;
  logic [4:0]  data5;
  logic [7:0]  data8;
  logic [15:0] cnt4;
  logic [2:0]  cnt5, cnt8;

  gray_codec_pipe #(.WIDTH(4), .CNT_W(16)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready4),
    .in_mode(in_mode), .in_data(din[3:0]), .out_valid(valid4),
    .out_ready(out_ready), .out_mode(mode4), .out_data(data4),
    .xfer_count(cnt4));

  gray_codec_pipe #(.WIDTH(5), .CNT_W(3)) u_dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready5),
    .in_mode(in_mode), .in_data(din[4:0]), .out_valid(valid5),
    .out_ready(out_ready), .out_mode(mode5), .out_data(data5),
    .xfer_count(cnt5));

  gray_codec_pipe #(.WIDTH(8), .CNT_W(3)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready8),
    .in_mode(in_mode), .in_data(din), .out_valid(valid8),
    .out_ready(out_ready), .out_mode(mode8), .out_data(data8),
    .xfer_count(cnt8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       m;
    logic [7:0] d;
    int         acc;
  } item_t;

  item_t      q[$];
  int         n_assert = 0;
  int         n_fail   = 0;
  int         n_xfer   = 0;
  int         cyc      = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data8;
  logic       prev_mode;

  // Reference: binary->Gray by definition; Gray->binary by searching for the
  // binary value whose Gray code equals the input.
  function automatic logic [31:0] ref_conv(input int w, input logic m,
                                           input logic [7:0] d);
    logic [31:0] mask;
    logic [31:0] x;
    logic [31:0] c;
    mask = (32'd1 << w) - 32'd1;
    x    = {24'd0, d} & mask;
    if (m) return (x ^ (x >> 1)) & mask;
    for (int k = 0; k < (1 << w); k++) begin
      c = 32'(k);
      if ((c ^ (c >> 1)) == x) return c;
    end
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check and update the model at the falling
  // edge, then check the counters just after the rising edge.
  task automatic step(input logic v, input logic m, input logic [7:0] d,
                      input logic ordy, input logic do_rst,
                      output logic accepted);
    item_t it;
    logic  exp_valid;
    rst = do_rst; in_valid = v; in_mode = m; din = d; out_ready = ordy;
    accepted = 1'b0;
    @(negedge clk);
    if (do_rst) begin
      q.delete();
      n_xfer     = 0;
      prev_stall = 1'b0;
    end else begin
      chk("in_ready4", {31'd0, ready4}, {31'd0, (q.size() < 2) || ordy});
      chk("in_ready5", {31'd0, ready5}, {31'd0, ready4});
      chk("in_ready8", {31'd0, ready8}, {31'd0, ready4});
      exp_valid = (q.size() > 0) && (cyc >= q[0].acc + 2);
      chk("out_valid4", {31'd0, valid4}, {31'd0, exp_valid});
      chk("out_valid5", {31'd0, valid5}, {31'd0, exp_valid});
      chk("out_valid8", {31'd0, valid8}, {31'd0, exp_valid});
      if (prev_stall && valid8) begin
        chk("hold_data8", {24'd0, data8}, {24'd0, prev_data8});
        chk("hold_mode8", {31'd0, mode8}, {31'd0, prev_mode});
      end
      prev_stall = valid8 && !ordy;
      prev_data8 = data8;
      prev_mode  = mode8;
      if (valid4 && ordy && q.size() > 0) begin
        it = q.pop_front();
        chk("data4", {28'd0, data4}, ref_conv(4, it.m, it.d));
        chk("data5", {27'd0, data5}, ref_conv(5, it.m, it.d));
        chk("data8", {24'd0, data8}, ref_conv(8, it.m, it.d));
        chk("mode8", {31'd0, mode8}, {31'd0, it.m});
        n_xfer++;
      end
      if (v && ready4) begin
        it.m = m; it.d = d; it.acc = cyc;
        q.push_back(it);
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("xfer_count4", {16'd0, cnt4}, {16'd0, 16'(n_xfer)});
    chk("xfer_count5", {29'd0, cnt5}, {29'd0, 3'(n_xfer)});
    chk("xfer_count8", {29'd0, cnt8}, {29'd0, 3'(n_xfer)});
  endtask

  task automatic drain();
    logic a;
    for (int k = 0; k < 12 && q.size() > 0; k++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, a);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, a);
    chk("drained", 32'(q.size()), 32'd0);
  endtask

  logic [3:0] gseq [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
  logic [7:0] bp_words [4] = '{8'h3C, 8'hA5, 8'h0F, 8'hE1};

  initial begin
    logic a;
    int   idx;
    int   n_acc;
    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; din = 8'h00; out_ready = 1'b0;
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, a);
    step(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, a);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, valid4}, 32'd0);
    chk("rst_out_data8", {24'd0, data8}, 32'd0);
    chk("rst_out_mode", {31'd0, mode4}, 32'd0);
    chk("rst_count", {16'd0, cnt4}, 32'd0);
    chk("rst_in_ready", {31'd0, ready4}, 32'd1);

    // Gray->binary and binary->Gray sweeps over all 4-bit words.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, {4'h0, gseq[i]}, 1'b1, 1'b0, a);
    drain();
    chk("sweep_count", {16'd0, cnt4}, 32'd16);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 8'(i), 1'b1, 1'b0, a);
    step(1'b1, 1'b0, 8'h0B, 1'b1, 1'b0, a);
    step(1'b1, 1'b1, 8'h0B, 1'b1, 1'b0, a);
    // Wide-word corner cases.
    step(1'b1, 1'b0, 8'hC0, 1'b1, 1'b0, a);
    step(1'b1, 1'b0, 8'h80, 1'b1, 1'b0, a);
    step(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, a);
    step(1'b1, 1'b0, 8'h10, 1'b1, 1'b0, a);
    drain();

    // Backpressure: four words offered while the output is stalled.
    idx = 0;
    for (int k = 0; k < 5; k++) begin
      step(idx < 4, idx[0], bp_words[idx % 4], 1'b0, 1'b0, a);
      if (a) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'd2);
    for (int k = 0; k < 10 && idx < 4; k++) begin
      step(1'b1, idx[0], bp_words[idx], 1'b1, 1'b0, a);
      if (a) idx++;
    end
    chk("bp_all_accepted", 32'(idx), 32'd4);
    drain();

    // Reset with both stages full: those words must never appear.
    step(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, a);
    step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, a);
    step(1'b1, 1'b0, 8'h33, 1'b1, 1'b1, a);
    chk("midrst_valid", {31'd0, valid4}, 32'd0);
    chk("midrst_count", {16'd0, cnt4}, 32'd0);
    chk("midrst_ready", {31'd0, ready4}, 32'd1);
    step(1'b1, 1'b1, 8'h21, 1'b1, 1'b0, a);
    step(1'b1, 1'b0, 8'h9C, 1'b1, 1'b0, a);
    drain();

    // Random mixed traffic; the 3-bit counters wrap repeatedly here.
    n_acc = 0;
    for (int k = 0; k < 120; k++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom),
           $urandom_range(0, 3) != 0, 1'b0, a);
      if (a) n_acc++;
    end
    drain();
    chk("random_accepted", 32'(n_acc > 20), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
